// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request outstanding
// and holds the returned instruction for decode and immediate extension.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic        redir_ok;

  assign misaligned = |redirect_pc[1:0];
  assign redir_ok   = redirect & ~misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= RESET_PC;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    err_d   = redirect & misaligned;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redir_ok) pc_d = redirect_pc;
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (redir_ok) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redir_ok) begin
          pc_d = redirect_pc;
          // A response landing with the redirect is the one being killed.
          if (imem_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            vld_d   = 1'b1;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (redir_ok) begin
          pc_d    = redirect_pc;
          vld_d   = 1'b0;
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = pc_q + 32'd4;
          vld_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc_plus4    = ipc_q + 32'd4;
  assign instr_valid = vld_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a transaction-level fetch model
// and a variable-latency instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fetch_err;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_plus4   (pc_plus4),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit en = 0;

  // reference state
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ipc = 32'h0;
  logic [31:0] m_instr = 32'h13;
  bit m_live = 0;
  bit m_stale = 0;
  bit m_err = 0;

  // memory state
  bit mp = 0;
  int mcnt = 0;
  logic [31:0] maddr = 32'h0;

  // knobs
  bit k_rst = 0, k_stall = 0, k_redir = 0, k_rand = 0, k_period = 0;
  logic [31:0] k_rpc = 32'h0;
  int k_L = 1;

  bit obs_req, obs_valid, prev_valid = 0;
  int cyc = 0, rises = 0, prev_rise = -1;

  function automatic logic [31:0] memfn(logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic r, s, rd, acc;
    logic [31:0] rp;
    @(negedge clk);
    cyc++;
    obs_req   = imem_req;
    obs_valid = instr_valid;
    if (en) begin
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_live});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("pc_plus4", pc_plus4, m_ipc + 32'd4);
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
      chk("req_busy", {31'b0, imem_req & (mp | m_live)}, 32'h0);
      if (instr_valid && !prev_valid) begin
        rises++;
        if (k_period && prev_rise >= 0)
          chk("period", cyc - prev_rise, k_L + 2);
        prev_rise = cyc;
      end
    end
    prev_valid = instr_valid;

    r = k_rst; s = k_stall; rd = k_redir; rp = k_rpc;
    if (k_rand) begin
      r  = ($urandom_range(0, 99) < 1);
      s  = ($urandom_range(0, 99) < 40);
      rd = ($urandom_range(0, 99) < 10);
      rp = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      k_L = $urandom_range(1, 4);
    end
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    imem_valid = mp && (mcnt == 0);
    imem_rdata = imem_valid ? memfn(maddr) : $urandom;

    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h13;
      m_live = 0; m_stale = 0; m_err = 0;
    end else begin
      acc   = rd && (rp[1:0] == 2'b00);
      m_err = rd && (rp[1:0] != 2'b00);
      if (acc) begin
        m_pc    = rp;
        m_live  = 0;
        m_stale = (mp || imem_req) && !imem_valid;
      end else if (imem_valid) begin
        if (m_stale) m_stale = 0;
        else begin
          m_live  = 1;
          m_ipc   = m_pc;
          m_instr = memfn(m_pc);
        end
      end else if (m_live && !s) begin
        m_pc   = m_pc + 32'd4;
        m_live = 0;
      end
    end

    if (r) mp = 0;
    else begin
      if (imem_valid) mp = 0;
      if (imem_req) begin
        mp = 1; maddr = imem_addr; mcnt = k_L - 1;
      end else if (mp && mcnt > 0) mcnt--;
    end
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      ok = obs_valid;
    end
    if (!ok) chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_req();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      ok = obs_req;
    end
    if (!ok) chk("wait_req_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_reset();
    k_rst = 1; tick(); tick(); k_rst = 0;
  endtask

  initial begin
    logic [31:0] snap, sipc;
    int r0;
    bit ok;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    imem_valid = 0; imem_rdata = 0;

    // first fetch after a two-cycle reset
    k_L = 1; k_rst = 1;
    tick(); en = 1; tick(); k_rst = 0;
    tick(); chk("p1_idle_req", {31'b0, obs_req}, 32'h0);
    tick(); chk("p1_req", {31'b0, obs_req}, 32'h1);
    chk("p1_addr", imem_addr, 32'h0);
    tick(); chk("p1_wait", {31'b0, obs_valid}, 32'h0);
    k_stall = 1;
    tick(); chk("p1_valid", {31'b0, obs_valid}, 32'h1);
    chk("p1_instr", instr, 32'h0050_0093);
    chk("p1_plus4", pc_plus4, 32'h4);

    // stall holds the instruction, no new request
    snap = m_ipc;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("p2_noreq", {31'b0, obs_req}, 32'h0);
    end
    k_stall = 0;
    tick();
    tick(); chk("p2_req", {31'b0, obs_req}, 32'h1);
    chk("p2_addr", imem_addr, snap + 32'd4);

    // redirect beats stall in VALID
    k_stall = 1; wait_valid();
    k_redir = 1; k_rpc = 32'h100;
    tick(); k_redir = 0;
    tick(); chk("p3_req", {31'b0, obs_req}, 32'h1);
    chk("p3_addr", imem_addr, 32'h100);
    chk("p3_novalid", {31'b0, obs_valid}, 32'h0);
    wait_valid(); chk("p3_ipc", instr_pc, 32'h100);

    // redirect while waiting on a slow response
    k_stall = 0; k_L = 1; do_reset();
    k_stall = 1; wait_valid(); k_stall = 0; tick();
    k_stall = 1; wait_valid(); k_stall = 0; k_L = 3;
    wait_req(); chk("p4_addr8", imem_addr, 32'h8);
    k_redir = 1; k_rpc = 32'h40;
    tick(); k_redir = 0;
    k_stall = 1; wait_valid();
    chk("p4_ipc", instr_pc, 32'h40);

    // misaligned redirect is rejected
    sipc = m_ipc;
    k_stall = 0; k_redir = 1; k_rpc = 32'h102;
    tick(); k_redir = 0;
    tick(); chk("p5_err", {31'b0, fetch_err}, 32'h1);
    chk("p5_req", {31'b0, obs_req}, 32'h1);
    chk("p5_addr", imem_addr, sipc + 32'd4);
    tick(); chk("p5_err_clr", {31'b0, fetch_err}, 32'h0);

    // reset during WAIT, then latency sweep
    k_L = 4; wait_req();
    k_rst = 1; tick(); k_rst = 0;
    tick(); chk("p6_valid", {31'b0, instr_valid}, 32'h0);
    chk("p6_instr", instr, 32'h13);
    chk("p6_addr", imem_addr, 32'h0);
    k_period = 1;
    r0 = rises;
    for (int L = 1; L <= 4; L++) begin
      int base;
      k_L = L; prev_rise = -1; base = rises; ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        tick();
        ok = (rises - base) >= 5;
      end
    end
    chk("p6_count", rises - r0, 20);
    k_period = 0;

    // random traffic
    r0 = rises;
    k_rand = 1;
    repeat (3000) tick();
    k_rand = 0;
    chk("progress", {31'b0, rises > r0 + 50}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
